// File: rtl/histogram_readout.sv
// rtl/histogram_readout.sv - drains the finished 256-bin histogram from scratch memory to output memory
//
// Purpose:
//   After the histogram build, reads NUM_WORDS scratch words (4 x 32-bit bins each) and writes
//   them to output memory at OUT_BASE+i. Words whose bit in the latched valid bitmap is clear
//   were never written during build, so their undefined contents are replaced by zero. The sum
//   of every bin written is accumulated into pixel_total.
//
// Ports:
//   clock                 in   1          system clock, rising edge
//   reset                 in   1          asynchronous active-low reset
//   start                 in   1          1-cycle drain request, sampled only in IDLE
//   word_valid_bitmap     in   NUM_WORDS  bit i set: scratch word i holds real data
//   scratch_read_address  out  16         scratch read address
//   scratch_rdata0        in   128        scratch read data, one cycle after the address
//   output_write_enable   out  1          output memory write strobe
//   output_write_address  out  16         output memory write address
//   output_wdata          out  128        output memory write data
//   pixel_total           out  32         running sum of all bins drained so far (mod 2^32)
//   busy                  out  1          drain in progress
//   done                  out  1          1-cycle pulse after the last write
module histogram_readout #(
  parameter int          NUM_WORDS = 64,
  parameter logic [15:0] OUT_BASE  = 16'h0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_WORDS-1:0] word_valid_bitmap,
  output logic [15:0]          scratch_read_address,
  input  logic [127:0]         scratch_rdata0,
  output logic                 output_write_enable,
  output logic [15:0]          output_write_address,
  output logic [127:0]         output_wdata,
  output logic [31:0]          pixel_total,
  output logic                 busy,
  output logic                 done
);

  localparam int             IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE_S
  } state_t;

  state_t               state;
  logic [NUM_WORDS-1:0] bitmap_q;
  logic [IW-1:0]        issue_idx;

  // Two-stage tracking of each issued read: rd_* is the cycle the address is on the bus,
  // dat_* is the cycle the scratch data for that address is present on scratch_rdata0.
  logic                 rd_vld;
  logic [IW-1:0]        rd_idx;
  logic                 dat_vld;
  logic [IW-1:0]        dat_idx;

  logic [127:0]         wr_data;
  logic [31:0]          lane_sum;

  always_comb begin
    wr_data  = '0;
    if (bitmap_q[dat_idx]) begin
      wr_data = scratch_rdata0;
    end
    lane_sum = wr_data[127:96] + wr_data[95:64] + wr_data[63:32] + wr_data[31:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      bitmap_q             <= '0;
      issue_idx            <= '0;
      rd_vld               <= 1'b0;
      rd_idx               <= '0;
      dat_vld              <= 1'b0;
      dat_idx              <= '0;
      scratch_read_address <= '0;
      output_write_enable  <= 1'b0;
      output_write_address <= '0;
      output_wdata         <= '0;
      pixel_total          <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      rd_vld              <= 1'b0;
      dat_vld             <= rd_vld;
      dat_idx             <= rd_idx;
      output_write_enable <= 1'b0;
      done                <= 1'b0;

      // Write stage runs independently of the FSM so the pipeline drains through DRAIN.
      if (dat_vld) begin
        output_write_enable  <= 1'b1;
        output_write_address <= OUT_BASE + 16'(dat_idx);
        output_wdata         <= wr_data;
        pixel_total          <= pixel_total + lane_sum;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            bitmap_q    <= word_valid_bitmap;
            pixel_total <= '0;
            issue_idx   <= '0;
          end
        end
        RUN: begin
          busy                 <= 1'b1;
          scratch_read_address <= 16'(issue_idx);
          rd_vld               <= 1'b1;
          rd_idx               <= issue_idx;
          issue_idx            <= issue_idx + 1'b1;
          if (issue_idx == LAST) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          busy <= 1'b1;
          if (dat_vld && (dat_idx == LAST)) begin
            state <= DONE_S;
          end
        end
        DONE_S: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_readout.sv
// tb/tb_histogram_readout.sv - self-checking bench for histogram_readout
module tb_histogram_readout;

  localparam int          NW   = 64;
  localparam logic [15:0] BASE = 16'hFFF0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   word_valid_bitmap = '0;
  logic [15:0]   scratch_read_address;
  logic [127:0]  scratch_rdata0 = '0;
  logic          output_write_enable;
  logic [15:0]   output_write_address;
  logic [127:0]  output_wdata;
  logic [31:0]   pixel_total;
  logic          busy;
  logic          done;

  histogram_readout #(.NUM_WORDS(NW), .OUT_BASE(BASE)) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .word_valid_bitmap    (word_valid_bitmap),
    .scratch_read_address (scratch_read_address),
    .scratch_rdata0       (scratch_rdata0),
    .output_write_enable  (output_write_enable),
    .output_write_address (output_write_address),
    .output_wdata         (output_wdata),
    .pixel_total          (pixel_total),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [127:0] mem [NW];
  always @(posedge clock) scratch_rdata0 <= mem[scratch_read_address[5:0]];

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
    int           at;
  } exp_t;

  exp_t sb[$];

  int          we_count;
  int          done_count;
  int          done_at;
  int          busy_count;
  int          busy_first;
  int          busy_last;
  logic [31:0] total_at_done;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (output_write_enable) begin
      we_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h at cycle %0d, expected no write", output_write_address, cyc);
      end else begin
        e = sb.pop_front();
        if (output_write_address !== e.addr || output_wdata !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL write_scoreboard: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                   output_write_address, output_wdata, cyc, e.addr, e.data, e.at);
        end
      end
    end
    if (done) begin
      done_count++;
      done_at       = cyc;
      total_at_done = pixel_total;
    end
    if (busy) begin
      busy_count++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  task clear_stats();
    we_count   = 0;
    done_count = 0;
    done_at    = -1;
    busy_count = 0;
    busy_first = -1;
    busy_last  = -1;
    total_at_done = '0;
  endtask

  task fill_ramp();
    for (int i = 0; i < NW; i++) begin
      mem[i] = {32'(i), 32'(i + 1), 32'(i + 2), 32'(i + 3)};
    end
  endtask

  task fill_ones();
    for (int i = 0; i < NW; i++) mem[i] = {128{1'b1}};
  endtask

  // Called at a negedge; start is sampled by the next rising edge, whose cycle number is t0.
  task launch(input logic [63:0] bm, output int t0);
    exp_t e;
    word_valid_bitmap = bm;
    start = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < NW; i++) begin
      e.addr = BASE + 16'(i);
      e.data = bm[i] ? mem[i] : 128'b0;
      e.at   = t0 + i + 3;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task wait_until(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (output_write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got we=%b busy=%b done=%b, expected 0 0 0", output_write_enable, busy, done);
    end
    checks++;
    if (pixel_total !== 32'd0) begin
      errors++;
      $display("FAIL reset_total: got %h, expected 0", pixel_total);
    end
    checks++;
    if (scratch_read_address !== 16'd0 || output_write_address !== 16'd0 || output_wdata !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got raddr=%h waddr=%h wdata=%h, expected all 0",
               scratch_read_address, output_write_address, output_wdata);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task test_pass_through();
    int t0;
    fill_ramp();
    clear_stats();
    launch({64{1'b1}}, t0);
    wait_until(t0 + 75);
    check_int("pass_sb_empty", sb.size(), 0);
    check_int("pass_write_count", we_count, 64);
    check_int("pass_done_count", done_count, 1);
    check_int("pass_done_cycle", done_at - t0, 67);
    check_int("pass_busy_first", busy_first - t0, 1);
    check_int("pass_busy_last", busy_last - t0, 66);
    check_int("pass_busy_count", busy_count, 66);
    checks++;
    if (total_at_done !== 32'd8448) begin
      errors++;
      $display("FAIL pass_total_at_done: got %0d, expected 8448", total_at_done);
    end
    checks++;
    if (pixel_total !== 32'd8448) begin
      errors++;
      $display("FAIL pass_total_stable: got %0d, expected 8448", pixel_total);
    end
  endtask

  task test_sparse_bitmap();
    int t0;
    fill_ones();
    clear_stats();
    launch(64'h0000_0000_0000_0001, t0);
    wait_until(t0 + 75);
    check_int("sparse_sb_empty", sb.size(), 0);
    check_int("sparse_write_count", we_count, 64);
    check_int("sparse_done_cycle", done_at - t0, 67);
    checks++;
    if (total_at_done !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL sparse_total: got %h, expected fffffffc", total_at_done);
    end
  endtask

  task test_start_while_busy();
    int t0;
    fill_ramp();
    clear_stats();
    launch({64{1'b1}}, t0);
    wait_until(t0 + 29);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_until(t0 + 66);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_until(t0 + 80);
    check_int("ignore_sb_empty", sb.size(), 0);
    check_int("ignore_write_count", we_count, 64);
    check_int("ignore_done_count", done_count, 1);
    check_int("ignore_done_cycle", done_at - t0, 67);
    check_int("ignore_busy_count", busy_count, 66);
    checks++;
    if (total_at_done !== 32'd8448) begin
      errors++;
      $display("FAIL ignore_total: got %0d, expected 8448", total_at_done);
    end
  endtask

  task test_bitmap_change();
    int t0;
    fill_ramp();
    clear_stats();
    launch({64{1'b1}}, t0);
    wait_until(t0 + 4);
    word_valid_bitmap = '0;
    wait_until(t0 + 75);
    check_int("latch_sb_empty", sb.size(), 0);
    checks++;
    if (total_at_done !== 32'd8448) begin
      errors++;
      $display("FAIL latch_total: got %0d, expected 8448", total_at_done);
    end
  endtask

  task test_reset_mid_drain();
    int t0;
    int wc;
    fill_ramp();
    clear_stats();
    launch({64{1'b1}}, t0);
    wait_until(t0 + 19);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (output_write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pixel_total !== 32'd0 ||
        scratch_read_address !== 16'd0 || output_write_address !== 16'd0 || output_wdata !== 128'd0) begin
      errors++;
      $display("FAIL midreset_async: got we=%b busy=%b done=%b total=%h raddr=%h waddr=%h, expected all 0",
               output_write_enable, busy, done, pixel_total, scratch_read_address, output_write_address);
    end
    sb.delete();
    wc = we_count;
    repeat (10) @(negedge clock);
    check_int("midreset_no_writes", we_count, wc);
    check_int("midreset_no_done", done_count, 0);
    reset = 1'b1;
    @(negedge clock);
    clear_stats();
    launch(64'h0000_0000_0000_0001, t0);
    wait_until(t0 + 75);
    check_int("restart_sb_empty", sb.size(), 0);
    check_int("restart_write_count", we_count, 64);
    checks++;
    if (total_at_done !== 32'd6) begin
      errors++;
      $display("FAIL restart_total: got %0d, expected 6", total_at_done);
    end
  endtask

  task test_back_to_back();
    int t0;
    int t1;
    fill_ramp();
    clear_stats();
    launch({64{1'b1}}, t0);
    wait_until(t0 + 67);
    launch(64'h0000_0000_0000_0001, t1);
    wait_until(t1 + 75);
    check_int("b2b_sb_empty", sb.size(), 0);
    check_int("b2b_write_count", we_count, 128);
    check_int("b2b_done_count", done_count, 2);
    check_int("b2b_done_cycle", done_at - t0, 68 + 67);
    checks++;
    if (total_at_done !== 32'd6) begin
      errors++;
      $display("FAIL b2b_total: got %0d, expected 6", total_at_done);
    end
  endtask

  initial begin
    clear_stats();
    fill_ramp();
    @(negedge clock);
    test_reset();
    test_pass_through();
    test_sparse_bitmap();
    test_start_while_busy();
    test_bitmap_change();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
